// File: rtl/water_tank_refill_ctrl_if.sv
// Signal bundle between the tank refill controller and its surroundings
// (level sensor, dispenser handshake, operator fault clear, valve drive).
//   master : the refill controller; samples enable/level/dispenser_busy/
//            fault_clear and drives valve, inhibit, status and debug outputs.
//   slave  : the environment side; drives the inputs and observes the outputs.
interface water_tank_refill_ctrl_if #(
  parameter int unsigned LEVEL_W = 8,
  parameter int unsigned TMO_W   = 16
);
  logic               enable;
  logic [LEVEL_W-1:0] level;
  logic               dispenser_busy;
  logic               fault_clear;
  logic               inlet_valve;
  logic               dispense_inhibit;
  logic               refill_active;
  logic               fault;
  logic [2:0]         state;
  logic [TMO_W-1:0]   fill_timer;

  modport master (
    input  enable, level, dispenser_busy, fault_clear,
    output inlet_valve, dispense_inhibit, refill_active, fault, state, fill_timer
  );

  modport slave (
    output enable, level, dispenser_busy, fault_clear,
    input  inlet_valve, dispense_inhibit, refill_active, fault, state, fill_timer
  );
endinterface

// File: rtl/water_tank_refill_ctrl.sv
// Refill controller for the dispenser reservoir. Debounces a low-level
// reading, waits for any active dispense to finish, opens the inlet valve
// until the tank reads full, lets the reading settle with the valve closed,
// and latches FAULT if one refill keeps the valve open too long.
// Ports:
//   clk    - system clock, rising edge
//   reset  - asynchronous, active-high reset
//   bus    - master side of water_tank_refill_ctrl_if:
//            in : enable, level, dispenser_busy, fault_clear
//            out: inlet_valve, dispense_inhibit, refill_active, fault,
//                 state (debug encoding), fill_timer
module water_tank_refill_ctrl #(
  parameter int unsigned LEVEL_W       = 8,
  parameter int unsigned LOW_THRESH    = 64,
  parameter int unsigned HIGH_THRESH   = 224,
  parameter int unsigned DEBOUNCE      = 3,
  parameter int unsigned SETTLE_CYCLES = 8,
  parameter int unsigned TMO_W         = 16,
  parameter int unsigned FILL_TIMEOUT  = 5000
) (
  input  logic                      clk,
  input  logic                      reset,
  water_tank_refill_ctrl_if.master  bus
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] WAIT   = 3'd1;
  localparam logic [2:0] FILL   = 3'd2;
  localparam logic [2:0] SETTLE = 3'd3;
  localparam logic [2:0] FAULT  = 3'd4;

  localparam logic [LEVEL_W-1:0] LOW_L       = LEVEL_W'(LOW_THRESH);
  localparam logic [LEVEL_W-1:0] HIGH_L      = LEVEL_W'(HIGH_THRESH);
  localparam logic [3:0]         DEB_L       = 4'(DEBOUNCE);
  localparam logic [7:0]         SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [TMO_W-1:0]   TMO_LAST    = TMO_W'(FILL_TIMEOUT - 1);

  logic [2:0]       state_q, state_d;
  logic [TMO_W-1:0] fill_timer_q, fill_timer_d;
  logic [3:0]       deb_q, deb_d;
  logic [7:0]       settle_q, settle_d;

  logic level_low, level_high, low_ok, timeout, settle_done;

  assign level_low   = (bus.level < LOW_L);
  assign level_high  = (bus.level >= HIGH_L);
  assign low_ok      = (deb_q == DEB_L);
  // ">=" rather than "==": a SETTLE entered on the timeout cycle resumes FILL
  // with the timer already past the last value, and must still trap.
  assign timeout     = (fill_timer_q >= TMO_LAST);
  assign settle_done = (settle_q == SETTLE_LAST);

  always_comb begin
    deb_d        = level_low ? ((deb_q == DEB_L) ? deb_q : deb_q + 4'd1) : '0;
    state_d      = state_q;
    fill_timer_d = fill_timer_q;
    settle_d     = settle_q;
    case (state_q)
      IDLE: begin
        if (bus.enable && low_ok) begin
          if (bus.dispenser_busy) begin
            state_d = WAIT;
          end else begin
            state_d      = FILL;
            fill_timer_d = '0;
          end
        end
      end
      WAIT: begin
        if (!bus.enable) begin
          state_d = IDLE;
        end else if (!bus.dispenser_busy) begin
          state_d      = FILL;
          fill_timer_d = '0;
        end
      end
      FILL: begin
        // Counts every valve-open cycle, including the one that leaves FILL.
        fill_timer_d = fill_timer_q + 1'b1;
        if (!bus.enable) begin
          state_d = IDLE;
        end else if (level_high) begin
          state_d  = SETTLE;
          settle_d = '0;
        end else if (timeout) begin
          state_d = FAULT;
        end
      end
      SETTLE: begin
        if (!bus.enable) begin
          state_d = IDLE;
        end else if (settle_done) begin
          state_d = level_high ? IDLE : FILL;
        end else begin
          settle_d = settle_q + 8'd1;
        end
      end
      FAULT: begin
        if (bus.fault_clear) begin
          state_d      = IDLE;
          fill_timer_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      fill_timer_q <= '0;
      deb_q        <= '0;
      settle_q     <= '0;
    end else begin
      state_q      <= state_d;
      fill_timer_q <= fill_timer_d;
      deb_q        <= deb_d;
      settle_q     <= settle_d;
    end
  end

  assign bus.inlet_valve      = (state_q == FILL);
  assign bus.dispense_inhibit = (state_q == WAIT) || (state_q == FILL) ||
                                (state_q == SETTLE) || (state_q == FAULT);
  assign bus.refill_active    = (state_q == WAIT) || (state_q == FILL) ||
                                (state_q == SETTLE);
  assign bus.fault            = (state_q == FAULT);
  assign bus.state            = state_q;
  assign bus.fill_timer       = fill_timer_q;

endmodule
